uart_baud_gen_frac: RTL and testbench
=====================================

// Module: uart_baud_gen_frac
// PURPOSE
//   Runtime-programmable fractional baud-rate generator for the UART TX/RX paths.
//   Divides clk by divInt + divFrac/2^FRAC_W to produce an oversampling tick.
//   Counts OVERSAMPLE ticks to produce bit-rate and bit-centre pulses.
//   Supports divisor reprogramming glitch-free at tick boundaries, plus a receiver phase resync.
// PARAMETERS
//   CLK_RATE     50_000_000  input clock frequency, Hz
//   DEFAULT_BAUD 19200       baud rate loaded at reset
//   OVERSAMPLE   16          sample ticks per bit, >=4, even
//   INT_W        16          width of integer divisor
//   FRAC_W       4           width of fractional divisor, in 1/2^FRAC_W clock units
// PORTS
//   clk         in   1                    system clock, rising edge
//   rstN        in   1                    asynchronous active-low reset
//   enable      in   1                    1 = run; 0 = freeze all counters, no ticks
//   phaseClr    in   1                    resync pulse: restart period and bit phase
//   divInt      in   INT_W                requested integer divisor, must be >=2
//   divFrac     in   FRAC_W               requested fractional divisor
//   divLoad     in   1                    1-cycle strobe: request new divisor
//   divPending  out  1                    new divisor captured, not yet applied
//   divErr      out  1                    1-cycle pulse: divLoad rejected (divInt<2)
//   sampleTick  out  1                    1-cycle pulse at OVERSAMPLE x baud
//   midTick     out  1                    1-cycle pulse at bit centre
//   bitTick     out  1                    1-cycle pulse at bit boundary
//   tickPhase   out  $clog2(OVERSAMPLE)   current sample index within the bit
// BEHAVIOUR
//   Reset (async assert, sync release): all outputs 0; cnt, acc and phase = 0.
//   Active divisor after reset: DEF_INT = floor(CLK_RATE/(DEFAULT_BAUD*OVERSAMPLE)).
//     DEF_FRAC = floor(CLK_RATE*2^FRAC_W/(DEFAULT_BAUD*OVERSAMPLE)) mod 2^FRAC_W.
//     With the defaults this gives 162 and 12.
//   Period: each sample period lasts P = actInt + c clocks.
//     c = carry out of (acc + actFrac) in FRAC_W bits.
//     acc <= (acc + actFrac) mod 2^FRAC_W at each sampleTick.
//     Long-run mean period = actInt + actFrac/2^FRAC_W.
//   Counter: cnt counts enabled cycles 0..P-1.
//     On the edge where cnt == P-1: cnt <= 0, and sampleTick is registered high for the next cycle.
//     With enable high from edge 0, the first sampleTick is visible after edge P.
//   Phase: tickPhase increments on every sampleTick and wraps OVERSAMPLE-1 -> 0.
//     bitTick is high in the same cycle as the sampleTick on which tickPhase becomes 0.
//     midTick is high in the same cycle as the sampleTick on which tickPhase becomes OVERSAMPLE/2.
//   All tick outputs are registered, 1-cycle wide, and never back-to-back (P >= 2).
//   enable = 0: cnt, acc and phase hold their values; ticks are 0; the next enable resumes mid-period.
//   phaseClr = 1 (takes priority over counting): cnt, acc and phase <= 0; no tick that cycle.
//     The next sampleTick follows P cycles later, so an RX can align to the start-bit edge.
//   Divisor load (divLoad high, divInt >= 2): {divInt, divFrac} is captured into pending; divPending <= 1.
//     The pending divisor becomes active on the edge that produces a sampleTick.
//     It becomes active immediately (next edge) if enable = 0 or phaseClr = 1.
//     divPending clears on the same edge the divisor becomes active.
//     acc is not cleared on a divisor change.
//   divLoad while divPending = 1: the pending value is overwritten; still applied at the next boundary.
//   divLoad with divInt < 2: divErr pulses for 1 cycle; pending and active divisors are unchanged.
//   divLoad on the same edge as a tick boundary: the old pending value (if any) is applied.
//     The new value is held pending until the next boundary.
//   Reset mid-operation: the active divisor returns to defaults, and pending and divErr are cleared.
// TESTING
//   1. Reset, enable=1, default divisor.
//      -> 16 ticks span 162*16 + 12 = 2604 cycles.
//      -> bitTick every 2604 +/- 1 cycles; tickPhase wraps 15 -> 0 on bitTick.
//   2. Load divInt=4, divFrac=0, OVERSAMPLE=16.
//      -> sampleTick every 4 cycles; midTick and bitTick 32 cycles apart.
//   3. Load divInt=4, divFrac=8 (FRAC_W=4), acc=0.
//      -> sample periods 4, 5, 4, 5, ...
//   4. Load new divisor mid-period.
//      -> divPending=1 until the next sampleTick, then 0.
//      -> The period in progress completes with the old divisor.
//      -> Two loads before the boundary: only the second is applied.
//   5. divLoad with divInt=1.
//      -> divErr high for exactly 1 cycle; period unchanged.
//   6. phaseClr at cnt=2 (divInt=4).
//      -> tickPhase=0 and the next sampleTick comes 4 cycles later.
//   6b. enable low for 10 cycles mid-period.
//      -> Period stretched by exactly 10 cycles; no ticks while low.
//   6c. rstN asserted mid-stream.
//      -> Outputs go to 0 immediately; defaults restored.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: divides clk by divInt + divFrac/2^FRAC_W into an
// oversampling tick, and derives bit-boundary and bit-centre pulses from it.
module uart_baud_gen_frac #(
    parameter int unsigned CLK_RATE     = 50_000_000,
    parameter int unsigned DEFAULT_BAUD = 19200,
    parameter int unsigned OVERSAMPLE   = 16,
    parameter int unsigned INT_W        = 16,
    parameter int unsigned FRAC_W       = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          enable,
    input  logic                          phaseClr,
    input  logic [INT_W-1:0]              divInt,
    input  logic [FRAC_W-1:0]             divFrac,
    input  logic                          divLoad,
    output logic                          divPending,
    output logic                          divErr,
    output logic                          sampleTick,
    output logic                          midTick,
    output logic                          bitTick,
    output logic [$clog2(OVERSAMPLE)-1:0] tickPhase
);

    localparam int unsigned       PH_W      = $clog2(OVERSAMPLE);
    localparam logic [63:0]       DEF_FIXED = (64'(CLK_RATE) << FRAC_W) /
                                              (64'(DEFAULT_BAUD) * 64'(OVERSAMPLE));
    localparam logic [INT_W-1:0]  DEF_INT   = INT_W'(DEF_FIXED >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC  = FRAC_W'(DEF_FIXED);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_MID    = PH_W'(OVERSAMPLE / 2);

    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [INT_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [INT_W-1:0]  pend_int_q, pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              sample_q, sample_d;
    logic              mid_q, mid_d;
    logic              bit_q, bit_d;

    logic [FRAC_W:0]   frac_sum;
    logic [INT_W:0]    last_cnt;
    logic              boundary;
    logic              load_ok;
    logic              apply;

    // Period length is actInt plus the carry of the fractional accumulator.
    // The >= compare lets a shorter divisor applied while paused still end the period.
    always_comb begin
        frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
        last_cnt = {1'b0, act_int_q} + {{INT_W{1'b0}}, frac_sum[FRAC_W]} - (INT_W+1)'(1);
        boundary = enable && !phaseClr && ({1'b0, cnt_q} >= last_cnt);
        load_ok  = divLoad && (divInt >= INT_W'(2));
        apply    = pend_q && (boundary || !enable || phaseClr);
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        phase_d     = phase_q;
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        pend_d      = pend_q;
        err_d       = divLoad && (divInt < INT_W'(2));
        sample_d    = 1'b0;
        mid_d       = 1'b0;
        bit_d       = 1'b0;

        if (phaseClr) begin
            cnt_d   = '0;
            acc_d   = '0;
            phase_d = '0;
        end else if (enable) begin
            if (boundary) begin
                cnt_d    = '0;
                acc_d    = frac_sum[FRAC_W-1:0];
                phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                sample_d = 1'b1;
                mid_d    = (phase_d == PH_MID);
                bit_d    = (phase_d == '0);
            end else begin
                cnt_d = cnt_q + INT_W'(1);
            end
        end

        // The previously pending divisor is applied before a same-edge load is captured.
        if (apply) begin
            act_int_d  = pend_int_q;
            act_frac_d = pend_frac_q;
        end
        if (load_ok) begin
            pend_int_d  = divInt;
            pend_frac_d = divFrac;
            pend_d      = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            act_int_q   <= DEF_INT;
            act_frac_q  <= DEF_FRAC;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            sample_q    <= 1'b0;
            mid_q       <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            sample_q    <= sample_d;
            mid_q       <= mid_d;
            bit_q       <= bit_d;
        end
    end

    assign divPending = pend_q;
    assign divErr     = err_q;
    assign sampleTick = sample_q;
    assign midTick    = mid_q;
    assign bitTick    = bit_q;
    assign tickPhase  = phase_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: divisor table, hand-written corner sequences and a
// randomized run checked against a deadline-based reference model.
module tb_uart_baud_gen_frac;

    localparam int unsigned OS = 16;
    localparam int unsigned IW = 16;
    localparam int unsigned FW = 4;

    logic          clk      = 1'b0;
    logic          rstN     = 1'b0;
    logic          enable   = 1'b0;
    logic          phaseClr = 1'b0;
    logic          divLoad  = 1'b0;
    logic [IW-1:0] divInt   = '0;
    logic [FW-1:0] divFrac  = '0;
    logic          divPending, divErr, sampleTick, midTick, bitTick;
    logic [3:0]    tickPhase;

    int total = 0;
    int bad   = 0;

    uart_baud_gen_frac #(
        .CLK_RATE    (50_000_000),
        .DEFAULT_BAUD(19200),
        .OVERSAMPLE  (OS),
        .INT_W       (IW),
        .FRAC_W      (FW)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .enable    (enable),
        .phaseClr  (phaseClr),
        .divInt    (divInt),
        .divFrac   (divFrac),
        .divLoad   (divLoad),
        .divPending(divPending),
        .divErr    (divErr),
        .sampleTick(sampleTick),
        .midTick   (midTick),
        .bitTick   (bitTick),
        .tickPhase (tickPhase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int di;
        int df;
        int p0;
        int p1;
        int p2;
        int p3;
    } div_vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({divPending, divErr, sampleTick, midTick, bitTick, tickPhase});
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0:       return sampleTick;
            1:       return midTick;
            2:       return bitTick;
            default: return divErr;
        endcase
    endfunction

    // Edges until the selected output is seen high; -1 if the budget runs out.
    task automatic wait_out(input int sel, input int limit, output int n);
        bit found = 1'b0;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            if (!found) begin
                cycle();
                if (pick(sel)) begin
                    n = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    // Load a divisor while paused, then phase-clear so cnt/acc/phase start from 0.
    task automatic set_div(input int di, input int df);
        enable  = 1'b0;
        divLoad = 1'b1;
        divInt  = IW'(di);
        divFrac = FW'(df);
        cycle();
        check("set_div_pending", int'(divPending), 1);
        divLoad  = 1'b0;
        phaseClr = 1'b1;
        cycle();
        check("set_div_applied", int'({divPending, tickPhase}), 0);
        phaseClr = 1'b0;
        enable   = 1'b1;
    endtask

    // Reference model: tracks the absolute edge number of the next tick.
    int m_e, m_dead, m_acc, m_phase, m_ai, m_af, m_pi, m_pf;
    bit m_pend;

    function automatic int m_period();
        return m_ai + (m_acc + m_af) / (1 << FW);
    endfunction

    task automatic m_reset();
        m_e     = 0;
        m_acc   = 0;
        m_phase = 0;
        m_ai    = 162;
        m_af    = 12;
        m_pend  = 1'b0;
        m_pi    = 0;
        m_pf    = 0;
        m_dead  = m_period();
    endtask

    task automatic m_step(input bit en, input bit clr, input bit ld, input int di,
                          input int df, output int exp_vec);
        bit tick, apply, err;
        m_e++;
        tick  = en && !clr && (m_e == m_dead);
        apply = m_pend && (tick || !en || clr);
        if (clr) begin
            m_acc   = 0;
            m_phase = 0;
        end else if (tick) begin
            m_acc   = (m_acc + m_af) % (1 << FW);
            m_phase = (m_phase + 1) % OS;
        end else if (!en) begin
            m_dead++;
        end
        if (apply) begin
            m_ai = m_pi;
            m_af = m_pf;
        end
        if (clr || tick) m_dead = m_e + m_period();
        err = ld && (di < 2);
        if (ld && di >= 2) begin
            m_pend = 1'b1;
            m_pi   = di;
            m_pf   = df;
        end else if (apply) begin
            m_pend = 1'b0;
        end
        exp_vec = int'({m_pend, err, tick, tick && (m_phase == OS/2), tick && (m_phase == 0),
                        4'(m_phase)});
    endtask

    initial begin
        div_vec_t vecs[5];
        int n, sum, seen, exp_vec, di, df;
        int exp_p[4];
        bit en, clr, ld;

        vecs[0] = '{di: 4, df: 0,  p0: 4, p1: 4, p2: 4, p3: 4};
        vecs[1] = '{di: 4, df: 8,  p0: 4, p1: 5, p2: 4, p3: 5};
        vecs[2] = '{di: 3, df: 4,  p0: 3, p1: 3, p2: 3, p3: 4};
        vecs[3] = '{di: 2, df: 15, p0: 2, p1: 3, p2: 3, p3: 3};
        vecs[4] = '{di: 5, df: 12, p0: 5, p1: 6, p2: 6, p3: 6};

        // Reset state and default divisor
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        enable = 1'b1;
        rstN   = 1'b1;
        wait_out(0, 400, n);
        check("default_first_period", n, 162);
        sum = n;
        for (int i = 2; i <= 16; i++) begin
            wait_out(0, 400, n);
            sum += n;
            if (i == 8)  check("default_mid_at_8", int'({midTick, bitTick, tickPhase}),
                               int'({1'b1, 1'b0, 4'd8}));
            if (i == 16) check("default_bit_at_16", int'({midTick, bitTick, tickPhase}),
                               int'({1'b0, 1'b1, 4'd0}));
        end
        check("default_16_ticks", sum, 2604);
        wait_out(2, 3000, n);
        check("default_bit_spacing", n, 2604);

        // Divisor table: first four sample periods from acc = 0
        foreach (vecs[v]) begin
            set_div(vecs[v].di, vecs[v].df);
            exp_p = '{vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3};
            for (int k = 0; k < 4; k++) begin
                wait_out(0, 50, n);
                check($sformatf("period_%0d_%0d_k%0d", vecs[v].di, vecs[v].df, k), n, exp_p[k]);
            end
        end

        // Mid-period loads: the period in progress keeps the old divisor; last load wins
        set_div(4, 0);
        divLoad = 1'b1;
        divInt  = 16'd6;
        divFrac = 4'd0;
        cycle();
        check("pending_after_load", int'(divPending), 1);
        divInt = 16'd7;
        cycle();
        divLoad = 1'b0;
        check("pending_after_reload", int'(divPending), 1);
        wait_out(0, 50, n);
        check("old_period_completes", n, 2);
        check("pending_cleared_at_tick", int'(divPending), 0);
        wait_out(0, 50, n);
        check("second_load_applied", n, 7);

        // Load on a boundary edge: old pending applied, new one held
        divLoad = 1'b1;
        divInt  = 16'd3;
        cycle();
        divLoad = 1'b0;
        repeat (5) cycle();
        divLoad = 1'b1;
        divInt  = 16'd9;
        cycle();
        divLoad = 1'b0;
        check("boundary_load_tick_pending", int'({sampleTick, divPending}), 3);
        wait_out(0, 50, n);
        check("boundary_old_pending_used", n, 3);
        check("boundary_pending_cleared", int'(divPending), 0);
        wait_out(0, 50, n);
        check("boundary_new_applied", n, 9);

        // Rejected load
        divLoad = 1'b1;
        divInt  = 16'd1;
        divFrac = 4'd3;
        cycle();
        divLoad = 1'b0;
        check("diverr_pulse", int'({divErr, divPending}), 2);
        cycle();
        check("diverr_one_cycle", int'(divErr), 0);
        wait_out(0, 50, n);
        check("diverr_period_unchanged", n, 7);
        wait_out(0, 50, n);
        check("diverr_next_period", n, 9);

        // phaseClr at cnt = 2 with a non-zero phase
        set_div(4, 0);
        repeat (3) wait_out(0, 50, n);
        check("phase_before_clr", int'(tickPhase), 3);
        cycle();
        cycle();
        phaseClr = 1'b1;
        cycle();
        phaseClr = 1'b0;
        check("phaseclr_state", int'({sampleTick, tickPhase}), 0);
        wait_out(0, 50, n);
        check("phaseclr_next_tick", n, 4);
        wait_out(1, 200, n);
        wait_out(2, 200, n);
        check("mid_to_bit_spacing", n, 32);

        // enable low for 10 cycles mid-period
        cycle();
        enable = 1'b0;
        seen   = 0;
        repeat (10) begin
            cycle();
            seen |= int'(sampleTick | midTick | bitTick);
        end
        check("no_ticks_disabled", seen, 0);
        enable = 1'b1;
        wait_out(0, 50, n);
        check("stretched_period_rest", n, 3);

        // Reset mid-stream
        divLoad = 1'b1;
        divInt  = 16'd5;
        cycle();
        divLoad = 1'b0;
        check("pending_before_reset", int'(divPending), 1);
        #2;
        rstN = 1'b0;
        #1;
        check("async_reset_outputs", outs(), 0);
        cycle();
        rstN = 1'b1;
        wait_out(0, 400, n);
        check("defaults_after_reset", n, 162);
        check("pending_after_reset", int'(divPending), 0);

        // Randomized run against the reference model
        rstN = 1'b0;
        cycle();
        enable   = 1'b1;
        phaseClr = 1'b0;
        divLoad  = 1'b0;
        rstN     = 1'b1;
        m_reset();
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (en && !m_pend && $urandom_range(0, 99) < 4) en = 1'b0;
            else if (!en && $urandom_range(0, 99) < 25) en = 1'b1;
            clr = ($urandom_range(0, 99) < 3);
            ld  = en && ($urandom_range(0, 99) < 6);
            di  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 9));
            df  = int'($urandom_range(0, 15));
            enable   = en;
            phaseClr = clr;
            divLoad  = ld;
            divInt   = IW'(di);
            divFrac  = FW'(df);
            m_step(en, clr, ld, di, df, exp_vec);
            cycle();
            check($sformatf("rand_cycle_%0d", c), outs(), exp_vec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
